// File: rtl/seq_divider32by16_if.sv
// Start/done handshake bundle between the ALU control and the sequential
// divider. The controller drives the request and operands; the divider
// returns status, results and error flags.
interface seq_divider32by16_if #(
    parameter int WIDTH = 16
);
    logic                 start;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 div_by_zero;
    logic                 overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider32by16.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, MSB first. Divide-by-zero and quotient
// overflow are detected up front and finish in a single cycle.
module seq_divider32by16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_divider32by16_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    // Iteration counter: 0..WIDTH-1 are shift/subtract cycles, WIDTH is the
    // result write-back cycle (still in RUN, but busy already low).
    logic [CW-1:0]      count;
    logic [WIDTH:0]     part_rem;
    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   divisor_reg;

    logic [WIDTH-1:0]   res_quotient;
    logic [WIDTH-1:0]   res_remainder;
    logic               flag_dz;
    logic               flag_ov;

    logic               accept;
    logic               iterate;
    logic               writeback;
    logic               zero_div;
    logic               ovf_div;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, subtract the divisor when it fits, and shift the outcome
    // into the quotient register. Returns {new remainder, new quotient}.
    function automatic logic [2*WIDTH:0] restore_step(
        input logic [WIDTH:0]   rem,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH:0] trial;
        logic [WIDTH:0] rem_next;
        logic           q_bit;
        trial = {rem[WIDTH-1:0], q[WIDTH-1]};
        if (trial >= {1'b0, d}) begin
            rem_next = trial - {1'b0, d};
            q_bit    = 1'b1;
        end else begin
            rem_next = trial;
            q_bit    = 1'b0;
        end
        return {rem_next, q[WIDTH-2:0], q_bit};
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and datapath control strobes. A quotient overflow
    // occurs exactly when the upper dividend half is not below the divisor,
    // so checking it at accept also keeps the partial remainder below the
    // divisor for the whole run.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        iterate    = 1'b0;
        writeback  = 1'b0;
        zero_div   = (bus.divisor == '0);
        ovf_div    = (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor);
        case (state)
            IDLE, FINISH: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = (zero_div || ovf_div) ? FINISH : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (count == LAST) begin
                    writeback  = 1'b1;
                    state_next = FINISH;
                end else begin
                    iterate    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latching, iteration datapath and result/flag registers.
    // Results hold until the next completion; flags clear on every accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count         <= '0;
            part_rem      <= '0;
            shift_q       <= '0;
            divisor_reg   <= '0;
            res_quotient  <= '0;
            res_remainder <= '0;
            flag_dz       <= 1'b0;
            flag_ov       <= 1'b0;
        end else if (accept) begin
            divisor_reg <= bus.divisor;
            part_rem    <= {1'b0, bus.dividend[2*WIDTH-1:WIDTH]};
            shift_q     <= bus.dividend[WIDTH-1:0];
            count       <= '0;
            flag_dz     <= zero_div;
            flag_ov     <= !zero_div && ovf_div;
            if (zero_div || ovf_div) begin
                res_quotient  <= '1;
                res_remainder <= '0;
            end
        end else if (iterate) begin
            {part_rem, shift_q} <= restore_step(part_rem, shift_q, divisor_reg);
            count               <= count + 1'b1;
        end else if (writeback) begin
            res_quotient  <= shift_q;
            res_remainder <= part_rem[WIDTH-1:0];
        end
    end

    assign bus.busy        = (state == RUN) && (count != LAST);
    assign bus.done        = (state == FINISH);
    assign bus.quotient    = res_quotient;
    assign bus.remainder   = res_remainder;
    assign bus.div_by_zero = flag_dz;
    assign bus.overflow    = flag_ov;

endmodule

// File: tb/tb_seq_divider32by16.sv
// Bench for the sequential 32/16 divider: fixed vectors, randomized
// operations against an arithmetic reference, and hand-written sequences
// for start-while-running, back-to-back accepts and mid-run reset.
module tb_seq_divider32by16;
    localparam int WIDTH = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_divider32by16_if #(.WIDTH(WIDTH)) bus ();

    seq_divider32by16 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dd;
        logic [15:0] ds;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present a request for one edge; returns at #1 after the accepting edge.
    task automatic start_op(input logic [31:0] dd, input logic [15:0] ds);
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = ds;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
    endtask

    // idx = number of edges after the current sample point until done is
    // seen (-1 if never); bcy = samples with busy high on the way.
    task automatic wait_done(output int idx, output int bcy);
        idx = -1;
        bcy = 0;
        for (int k = 0; k <= 40; k++) begin
            if (bus.busy) bcy++;
            if (bus.done) begin
                idx = k;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [31:0] dd, input logic [15:0] ds,
                                 input logic [15:0] eq, input logic [15:0] er,
                                 input logic edz, input logic eov);
        int idx;
        int bcy;
        logic err;
        err = edz | eov;
        start_op(dd, ds);
        wait_done(idx, bcy);
        chk({tag, "_latency"}, 64'(idx), err ? 64'd0 : 64'(WIDTH + 1));
        chk({tag, "_busy_cycles"}, 64'(bcy), err ? 64'd0 : 64'(WIDTH));
        chk({tag, "_quotient"}, bus.quotient, eq);
        chk({tag, "_remainder"}, bus.remainder, er);
        chk({tag, "_div_by_zero"}, bus.div_by_zero, edz);
        chk({tag, "_overflow"}, bus.overflow, eov);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, bus.done, 1'b0);
        chk({tag, "_quotient_hold"}, bus.quotient, eq);
    endtask

    // Reference: plain unsigned division with the error rules applied first.
    task automatic model(input logic [31:0] dd, input logic [15:0] ds,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dz, output logic ov);
        logic [31:0] qq;
        logic [31:0] rr;
        dz = 1'b0;
        ov = 1'b0;
        if (ds == 16'd0) begin
            dz = 1'b1;
            q  = 16'hFFFF;
            r  = 16'h0000;
        end else if ((dd / {16'd0, ds}) > 32'h0000_FFFF) begin
            ov = 1'b1;
            q  = 16'hFFFF;
            r  = 16'h0000;
        end else begin
            qq = dd / {16'd0, ds};
            rr = dd % {16'd0, ds};
            q  = qq[15:0];
            r  = rr[15:0];
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int bcy;
        logic [31:0] dd;
        logic [15:0] ds;
        logic [15:0] mq;
        logic [15:0] mr;
        logic mdz;
        logic mov;

        checks = 0;
        errors = 0;

        vecs[0] = '{32'h0000_0000, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{32'h000D_FFF2, 16'hFFFF, 16'h000E, 16'h0000, 1'b0, 1'b0};
        vecs[2] = '{32'h000D_FFF2, 16'h000E, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
        vecs[3] = '{32'd100,       16'd7,    16'd14,   16'd2,    1'b0, 1'b0};
        vecs[4] = '{32'd9,         16'd3,    16'd3,    16'd0,    1'b0, 1'b0};
        vecs[5] = '{32'h1234_5678, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{32'h0001_0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
        vecs[7] = '{32'hFFFE_FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0};
        vecs[8] = '{32'h0007_0000, 16'h0007, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
        vecs[9] = '{32'hFFFF_0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0};

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_quotient", bus.quotient, 16'h0);
        chk("rst_remainder", bus.remainder, 16'h0);
        chk("rst_flags", {bus.div_by_zero, bus.overflow}, 2'b00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_done", bus.done, 1'b0);

        // Fixed vectors
        for (int i = 0; i < 10; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].dd, vecs[i].ds,
                          vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov);
        end

        // Start during RUN is ignored; then a back-to-back accept in FINISH
        start_op(32'h000D_FFF2, 16'hFFFF);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        bus.start    = 1'b1;
        bus.dividend = 32'd9;
        bus.divisor  = 16'd3;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        wait_done(idx, bcy);
        chk("ign_latency", 64'(idx), 64'(WIDTH + 1 - 6));
        chk("ign_quotient", bus.quotient, 16'h000E);
        chk("ign_remainder", bus.remainder, 16'h0000);
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 16'd7;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        chk("b2b_done_low", bus.done, 1'b0);
        chk("b2b_busy", bus.busy, 1'b1);
        chk("b2b_quotient_held", bus.quotient, 16'h000E);
        wait_done(idx, bcy);
        chk("b2b_latency", 64'(idx), 64'(WIDTH + 1));
        chk("b2b_quotient", bus.quotient, 16'd14);
        chk("b2b_remainder", bus.remainder, 16'd2);

        // Error result followed immediately by a normal accept: flags clear
        start_op(32'h1234_5678, 16'h0000);
        chk("dz_done", bus.done, 1'b1);
        chk("dz_flag", bus.div_by_zero, 1'b1);
        start_op(32'd100, 16'd7);
        chk("clr_div_by_zero", bus.div_by_zero, 1'b0);
        chk("clr_quotient_held", bus.quotient, 16'hFFFF);
        wait_done(idx, bcy);
        chk("clr_latency", 64'(idx), 64'(WIDTH + 1));
        chk("clr_quotient", bus.quotient, 16'd14);
        chk("clr_remainder", bus.remainder, 16'd2);
        @(posedge clk);
        #1;

        // Reset in the middle of a run aborts it without a done pulse
        start_op(32'd100, 16'd7);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_busy", bus.busy, 1'b0);
        chk("mrst_done", bus.done, 1'b0);
        chk("mrst_quotient", bus.quotient, 16'h0);
        rst_n = 1'b1;
        idx = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) idx++;
        end
        chk("mrst_no_done", 64'(idx), 64'd0);
        run_and_check("mrst_after", 32'd9, 16'd3, 16'd3, 16'd0, 1'b0, 1'b0);

        // Randomized operations against the arithmetic reference
        for (int n = 0; n < 150; n++) begin
            ds = 16'($urandom_range(1, 65535));
            case ($urandom_range(0, 7))
                0:       dd = $urandom;
                1: begin
                    dd = $urandom;
                    ds = 16'h0000;
                end
                2:       dd = {ds, 16'($urandom)};
                default: dd = 32'($urandom_range(0, 65535)) * {16'd0, ds} + ($urandom % {16'd0, ds});
            endcase
            model(dd, ds, mq, mr, mdz, mov);
            run_and_check($sformatf("rnd%0d", n), dd, ds, mq, mr, mdz, mov);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
